// File: rtl/fetch_seq_ctrl_if.sv
// Instruction memory request/response channel between fetch sequencer and memory.
// Master issues req/addr; slave returns ready/rdata (ready may coincide with req).
interface fetch_seq_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_addr,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/fetch_seq_ctrl.sv
// Fetch-stage sequencer for variable-latency instruction memory.
// Owns the F->D register, squashes stale responses, tracks timeouts and stalls.
module fetch_seq_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_f,
  input  logic              redirect_e,
  input  logic [ADDR_W-1:0] redirect_e_addr,
  input  logic              redirect_w,
  input  logic [ADDR_W-1:0] redirect_w_addr,
  input  logic              stall_d,
  fetch_seq_ctrl_if.master  imem,
  output logic              stall_f,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_load_addr,
  output logic [31:0]       instr_d,
  output logic              valid_d,
  output logic              fetch_err,
  output logic [31:0]       stall_count
);

  localparam int WW = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [WW-1:0] TMAX = WW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    REQ     = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t            state;
  logic [31:0]       hold_buf;
  logic [ADDR_W-1:0] disc_addr;
  logic [WW-1:0]     wait_cnt;
  logic              redir;
  logic              ready;

  assign redir = redirect_e | redirect_w;
  assign ready = imem.mem_ready;

  always_comb begin
    imem.mem_req  = 1'b0;
    imem.mem_addr = pc_f;
    stall_f       = 1'b1;
    pc_load       = 1'b0;
    pc_load_addr  = redirect_e ? redirect_e_addr : redirect_w_addr;
    if (!rst) begin
      imem.mem_req = (state != HOLD);
      if (state == DISCARD) imem.mem_addr = disc_addr;
      pc_load = redir;
      if (!redir) begin
        unique case (state)
          REQ:     stall_f = !(ready && !stall_d);
          HOLD:    stall_f = stall_d;
          default: stall_f = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= REQ;
      instr_d     <= '0;
      valid_d     <= 1'b0;
      fetch_err   <= 1'b0;
      stall_count <= '0;
      wait_cnt    <= '0;
      hold_buf    <= '0;
      disc_addr   <= '0;
    end else begin
      if (stall_f) stall_count <= stall_count + 32'd1;

      // wait counter saturates; the error flag stays set until reset
      if (imem.mem_req && !ready) begin
        if (wait_cnt == TMAX) fetch_err <= 1'b1;
        else wait_cnt <= wait_cnt + WW'(1);
      end else begin
        wait_cnt <= '0;
      end

      if (redir) begin
        instr_d <= '0;
        valid_d <= 1'b0;
        if (!ready && state != HOLD) begin
          state <= DISCARD;
          if (state == REQ) disc_addr <= pc_f;
        end else begin
          state <= REQ;
        end
      end else begin
        unique case (state)
          REQ: begin
            if (ready && !stall_d) begin
              instr_d <= imem.mem_rdata;
              valid_d <= 1'b1;
            end else if (ready) begin
              hold_buf <= imem.mem_rdata;
              state    <= HOLD;
            end else if (!stall_d) begin
              valid_d <= 1'b0;
            end
          end
          HOLD: begin
            if (!stall_d) begin
              instr_d <= hold_buf;
              valid_d <= 1'b1;
              state   <= REQ;
            end
          end
          DISCARD: begin
            if (!stall_d) valid_d <= 1'b0;
            if (ready) state <= REQ;
          end
          default: state <= REQ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Bench for fetch_seq_ctrl: directed vector table, timeout sequence,
// and randomized traffic against a queue-based reference model.
module tb_fetch_seq_ctrl;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_f;
  logic        redirect_e;
  logic [31:0] redirect_e_addr;
  logic        redirect_w;
  logic [31:0] redirect_w_addr;
  logic        stall_d;
  logic        stall_f;
  logic        pc_load;
  logic [31:0] pc_load_addr;
  logic [31:0] instr_d;
  logic        valid_d;
  logic        fetch_err;
  logic [31:0] stall_count;

  int checks = 0;
  int errors = 0;

  fetch_seq_ctrl_if #(.ADDR_W(32)) imem ();

  fetch_seq_ctrl #(
    .ADDR_W(32),
    .TIMEOUT_CYC(T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pc_f(pc_f),
    .redirect_e(redirect_e),
    .redirect_e_addr(redirect_e_addr),
    .redirect_w(redirect_w),
    .redirect_w_addr(redirect_w_addr),
    .stall_d(stall_d),
    .imem(imem.master),
    .stall_f(stall_f),
    .pc_load(pc_load),
    .pc_load_addr(pc_load_addr),
    .instr_d(instr_d),
    .valid_d(valid_d),
    .fetch_err(fetch_err),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] w(input logic [31:0] a);
    return 32'hC0DE_0000 ^ {a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        re;
    logic        rw;
    logic [31:0] ea;
    logic [31:0] wa;
    logic        sd;
    logic        rdy;
    logic        x_req;
    logic [31:0] x_addr;
    logic        x_stall;
    logic        x_pcl;
    logic [31:0] x_pla;
    logic [31:0] x_instr;
    logic        x_valid;
    logic [31:0] x_cnt;
  } vec_t;

  vec_t tv[21];

  // reference model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_valid;
  logic        m_err;
  logic [31:0] m_cnt;
  int          m_wait;
  logic        m_stale;
  logic [31:0] m_stale_addr;
  logic [31:0] m_q[$];

  task automatic idle_inputs();
    redirect_e      = 1'b0;
    redirect_w      = 1'b0;
    redirect_e_addr = '0;
    redirect_w_addr = '0;
    stall_d         = 1'b0;
    imem.mem_ready  = 1'b0;
    imem.mem_rdata  = 32'hBAD0_BAD0;
    pc_f            = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic model_cycle(input logic re, input logic rw,
                             input logic [31:0] ea, input logic [31:0] wa,
                             input logic sd, input logic rdy,
                             input logic [31:0] rdata);
    logic        redir;
    logic        req;
    logic [31:0] addr;
    logic        stall;
    logic [31:0] pla;
    redir = re | rw;
    req   = (m_q.size() == 0);
    addr  = m_stale ? m_stale_addr : m_pc;
    pla   = re ? ea : wa;
    if (redir)                stall = 1'b1;
    else if (m_q.size() != 0) stall = sd;
    else if (m_stale)         stall = 1'b1;
    else                      stall = !(rdy && !sd);

    chk("rnd_mem_req", {31'd0, imem.mem_req}, {31'd0, req});
    if (req) chk("rnd_mem_addr", imem.mem_addr, addr);
    chk("rnd_stall_f", {31'd0, stall_f}, {31'd0, stall});
    chk("rnd_pc_load", {31'd0, pc_load}, {31'd0, redir});
    if (redir) chk("rnd_pc_load_addr", pc_load_addr, pla);
    chk("rnd_instr_d", instr_d, m_instr);
    chk("rnd_valid_d", {31'd0, valid_d}, {31'd0, m_valid});
    chk("rnd_fetch_err", {31'd0, fetch_err}, {31'd0, m_err});
    chk("rnd_stall_count", stall_count, m_cnt);

    if (req && !rdy) begin
      if (m_wait == T) m_err = 1'b1;
      else m_wait++;
    end else begin
      m_wait = 0;
    end
    if (stall) m_cnt = m_cnt + 32'd1;

    if (redir) begin
      m_instr = '0;
      m_valid = 1'b0;
      if (req && !rdy) begin
        if (!m_stale) m_stale_addr = m_pc;
        m_stale = 1'b1;
      end else begin
        m_stale = 1'b0;
      end
      m_q.delete();
    end else if (m_q.size() != 0) begin
      if (!sd) begin
        m_instr = m_q.pop_front();
        m_valid = 1'b1;
      end
    end else if (m_stale) begin
      if (!sd) m_valid = 1'b0;
      if (rdy) m_stale = 1'b0;
    end else if (rdy && !sd) begin
      m_instr = rdata;
      m_valid = 1'b1;
    end else if (rdy) begin
      m_q.push_back(rdata);
    end else if (!sd) begin
      m_valid = 1'b0;
    end

    if (redir)       m_pc = pla;
    else if (!stall) m_pc = m_pc + 32'd4;
  endtask

  initial begin
    tv[0]  = '{32'h000, 0, 0, 0, 0, 0, 1, 1, 32'h000, 0, 0, 0, 0, 0, 0};
    tv[1]  = '{32'h004, 0, 0, 0, 0, 0, 1, 1, 32'h004, 0, 0, 0, w(32'h000), 1, 0};
    tv[2]  = '{32'h008, 0, 0, 0, 0, 0, 1, 1, 32'h008, 0, 0, 0, w(32'h004), 1, 0};
    tv[3]  = '{32'h010, 0, 0, 0, 0, 0, 0, 1, 32'h010, 1, 0, 0, w(32'h008), 1, 0};
    tv[4]  = '{32'h010, 0, 0, 0, 0, 0, 0, 1, 32'h010, 1, 0, 0, w(32'h008), 0, 1};
    tv[5]  = '{32'h010, 0, 0, 0, 0, 0, 0, 1, 32'h010, 1, 0, 0, w(32'h008), 0, 2};
    tv[6]  = '{32'h010, 0, 0, 0, 0, 0, 1, 1, 32'h010, 0, 0, 0, w(32'h008), 0, 3};
    tv[7]  = '{32'h014, 0, 0, 0, 0, 1, 1, 1, 32'h014, 1, 0, 0, w(32'h010), 1, 3};
    tv[8]  = '{32'h014, 0, 0, 0, 0, 1, 0, 0, 32'h014, 1, 0, 0, w(32'h010), 1, 4};
    tv[9]  = '{32'h014, 0, 0, 0, 0, 0, 0, 0, 32'h014, 0, 0, 0, w(32'h010), 1, 5};
    tv[10] = '{32'h020, 0, 0, 0, 0, 0, 0, 1, 32'h020, 1, 0, 0, w(32'h014), 1, 5};
    tv[11] = '{32'h020, 1, 0, 32'h40, 0, 0, 0, 1, 32'h020, 1, 1, 32'h40,
               w(32'h014), 0, 6};
    tv[12] = '{32'h040, 0, 0, 0, 0, 0, 0, 1, 32'h020, 1, 0, 0, 0, 0, 7};
    tv[13] = '{32'h040, 0, 0, 0, 0, 0, 1, 1, 32'h020, 1, 0, 0, 0, 0, 8};
    tv[14] = '{32'h040, 0, 0, 0, 0, 0, 1, 1, 32'h040, 0, 0, 0, 0, 0, 9};
    tv[15] = '{32'h044, 1, 1, 32'h80, 32'h100, 1, 1, 1, 32'h044, 1, 1, 32'h80,
               w(32'h040), 1, 9};
    tv[16] = '{32'h080, 0, 0, 0, 0, 0, 1, 1, 32'h080, 0, 0, 0, 0, 0, 10};
    tv[17] = '{32'h084, 0, 1, 0, 32'h100, 1, 0, 1, 32'h084, 1, 1, 32'h100,
               w(32'h080), 1, 10};
    tv[18] = '{32'h100, 0, 0, 0, 0, 0, 1, 1, 32'h084, 1, 0, 0, 0, 0, 11};
    tv[19] = '{32'h100, 0, 0, 0, 0, 0, 1, 1, 32'h100, 0, 0, 0, 0, 0, 12};
    tv[20] = '{32'h104, 0, 0, 0, 0, 0, 0, 1, 32'h104, 1, 0, 0, w(32'h100), 1, 12};

    // reset: redirect asserted must not reach the PC or memory
    rst = 1'b1;
    idle_inputs();
    redirect_e      = 1'b1;
    redirect_e_addr = 32'h40;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_mem_req", {31'd0, imem.mem_req}, 32'd0);
      chk("rst_pc_load", {31'd0, pc_load}, 32'd0);
      chk("rst_stall_f", {31'd0, stall_f}, 32'd1);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    idle_inputs();

    for (int i = 0; i < 21; i++) begin
      pc_f            = tv[i].pc;
      redirect_e      = tv[i].re;
      redirect_w      = tv[i].rw;
      redirect_e_addr = tv[i].ea;
      redirect_w_addr = tv[i].wa;
      stall_d         = tv[i].sd;
      imem.mem_ready  = tv[i].rdy;
      imem.mem_rdata  = tv[i].rdy ? w(tv[i].x_addr) : 32'hBAD0_BAD0;
      @(negedge clk);
      chk($sformatf("v%0d_mem_req", i), {31'd0, imem.mem_req},
          {31'd0, tv[i].x_req});
      if (tv[i].x_req)
        chk($sformatf("v%0d_mem_addr", i), imem.mem_addr, tv[i].x_addr);
      chk($sformatf("v%0d_stall_f", i), {31'd0, stall_f},
          {31'd0, tv[i].x_stall});
      chk($sformatf("v%0d_pc_load", i), {31'd0, pc_load},
          {31'd0, tv[i].x_pcl});
      if (tv[i].x_pcl)
        chk($sformatf("v%0d_pc_load_addr", i), pc_load_addr, tv[i].x_pla);
      chk($sformatf("v%0d_instr_d", i), instr_d, tv[i].x_instr);
      chk($sformatf("v%0d_valid_d", i), {31'd0, valid_d},
          {31'd0, tv[i].x_valid});
      chk($sformatf("v%0d_stall_count", i), stall_count, tv[i].x_cnt);
      chk($sformatf("v%0d_fetch_err", i), {31'd0, fetch_err}, 32'd0);
      @(posedge clk); #1;
    end

    // timeout: flag appears after the (T+1)th wait cycle and is sticky
    do_reset();
    for (int k = 1; k <= T + 2; k++) begin
      @(negedge clk);
      chk($sformatf("to_wait%0d_fetch_err", k), {31'd0, fetch_err},
          (k > T + 1) ? 32'd1 : 32'd0);
      chk($sformatf("to_wait%0d_mem_req", k), {31'd0, imem.mem_req}, 32'd1);
      @(posedge clk); #1;
    end
    imem.mem_ready = 1'b1;
    imem.mem_rdata = w(32'h0);
    @(posedge clk); #1;
    imem.mem_ready = 1'b0;
    @(negedge clk);
    chk("to_sticky_fetch_err", {31'd0, fetch_err}, 32'd1);
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    chk("to_cleared_fetch_err", {31'd0, fetch_err}, 32'd0);
    @(posedge clk); #1;

    // randomized traffic against the reference model
    do_reset();
    m_pc = '0; m_instr = '0; m_valid = 1'b0; m_err = 1'b0;
    m_cnt = '0; m_wait = 0; m_stale = 1'b0; m_stale_addr = '0;
    m_q.delete();
    for (int n = 0; n < 3000; n++) begin
      logic        re, rw, sd, rdy;
      logic [31:0] ea, wa, rdata, addr;
      re    = ($urandom_range(0, 9) == 0);
      rw    = ($urandom_range(0, 9) == 0);
      ea    = $urandom & 32'hFFFF_FFFC;
      wa    = $urandom & 32'hFFFF_FFFC;
      sd    = ($urandom_range(0, 2) == 0);
      rdy   = ($urandom_range(0, 3) != 0);
      addr  = m_stale ? m_stale_addr : m_pc;
      rdata = rdy ? w(addr) : $urandom;
      pc_f            = m_pc;
      redirect_e      = re;
      redirect_w      = rw;
      redirect_e_addr = ea;
      redirect_w_addr = wa;
      stall_d         = sd;
      imem.mem_ready  = rdy;
      imem.mem_rdata  = rdata;
      @(negedge clk);
      model_cycle(re, rw, ea, wa, sd, rdy, rdata);
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_seq_ctrl.md
Name: fetch_seq_ctrl

Overview:
Sequencing controller for the pipelined fetch stage when instruction memory has variable latency (req/ready handshake).
- Gates PC advance with stall_f.
- Owns the F→D instruction register (instr_d/valid_d).
- Honours branch/writeback redirects that arrive mid-access by squashing the stale response.
- Reports memory timeout and stall statistics.

Parameters:
ADDR_W, 32, PC / memory address width
TIMEOUT_CYC, 255, consecutive wait cycles on one access before fetch_err sets

Ports:
clk  in  1  clock
rst  in  1  reset
pc_f  in  ADDR_W  current fetch PC (fetch-stage PC register)
redirect_e  in  1  branch taken in Execute
redirect_e_addr  in  ADDR_W  branch target
redirect_w  in  1  PC written in Writeback
redirect_w_addr  in  ADDR_W  writeback PC value
stall_d  in  1  decode stall from hazard unit
mem_req  out  1  instruction memory request
mem_addr  out  ADDR_W  request address
mem_ready  in  1  response valid this cycle (may be same cycle as request)
mem_rdata  in  32  instruction word
stall_f  out  1  1 = hold PC register
pc_load  out  1  1 = PC register loads pc_load_addr next edge; overrides stall_f
pc_load_addr  out  ADDR_W  redirect target
instr_d  out  32  instruction to Decode (registered)
valid_d  out  1  instr_d valid (registered)
fetch_err  out  1  sticky timeout flag
stall_count  out  32  cycles with stall_f=1, wraps modulo 2^32

Behaviour:
- Reset: rst synchronous, active-high; clock clk.
  - State REQ; instr_d=0, valid_d=0, fetch_err=0, stall_count=0.
  - Wait counter, hold buffer, discard address all 0.
  - While rst=1: mem_req=0, pc_load=0, stall_f=1, and stall_count does not count.
- States:
  - REQ: mem_req=1, mem_addr=pc_f (combinational; pc_f is stable because stall_f=1 until accept).
  - HOLD: mem_req=0; buffered word awaiting Decode.
  - DISCARD: mem_req=1, mem_addr=disc_addr; the response will be dropped.
- Redirect (highest priority, any state): pc_load=1, stall_f=1.
  - pc_load_addr = redirect_e ? redirect_e_addr : redirect_w_addr (E wins if both are asserted).
  - At the edge: valid_d<=0, instr_d<=0, regardless of stall_d.
  - Next state: DISCARD with disc_addr<=pc_f if REQ & !mem_ready; stays DISCARD if DISCARD & !mem_ready; otherwise REQ (any ready data is dropped, and the HOLD buffer is dropped).
- REQ, no redirect:
  - mem_ready & !stall_d (accept): stall_f=0; instr_d<=mem_rdata, valid_d<=1; stay REQ. Yields 1 instr/cycle with zero-wait memory.
  - mem_ready & stall_d: buffer<=mem_rdata, →HOLD; stall_f=1; instr_d/valid_d hold.
  - !mem_ready: stall_f=1. If !stall_d, valid_d<=0 (bubble); otherwise hold.
- HOLD, no redirect: stall_f=stall_d.
  - When !stall_d: instr_d<=buffer, valid_d<=1, →REQ (PC advances the same edge).
- DISCARD, no redirect: stall_f=1; valid_d<=0 if !stall_d.
  - On mem_ready: data dropped, →REQ.
- Timeout:
  - wait_cnt increments each cycle with mem_req & !mem_ready; saturates at TIMEOUT_CYC.
  - Clears on mem_ready or whenever mem_req=0.
  - When wait_cnt==TIMEOUT_CYC, fetch_err<=1, sticky until rst.
  - No recovery action; the request stays asserted.
- stall_count: +1 every non-reset cycle with stall_f=1, including redirect cycles.
- Reset mid-access: the outstanding response is not tracked. After reset, the first request is at pc_f (0).

Test Plan:
- Zero-wait memory (mem_ready tied 1), pc_f sequence 0,4,8 → stall_f=0 each cycle; instr_d follows mem_rdata one cycle later with valid_d=1; stall_count=0.
- mem_ready 3 cycles after request at pc_f=0x10 → stall_f=1 for 3 cycles; valid_d=0 during the wait; stall_count=3; instr_d=word@0x10 after accept.
- Response arrives with stall_d=1 for 2 cycles → HOLD; mem_req=0; instr_d unchanged. When stall_d drops, instr_d=buffered word, valid_d=1, stall_f=0 that cycle.
- redirect_e=1 (addr 0x40) while the request to 0x20 is pending:
  - Same cycle: pc_load=1, pc_load_addr=0x40.
  - Next cycle: mem_addr stays 0x20 (DISCARD).
  - The 0x20 data is dropped, valid_d=0; the next request goes to 0x40.
- redirect_e (0x80) and redirect_w (0x100) in the same cycle with mem_ready=1 and stall_d=1 → pc_load_addr=0x80; valid_d=0; data dropped; state REQ.
- TIMEOUT_CYC=4, mem_ready held 0 → fetch_err=1 after the 5th wait cycle; stays 1 after a later mem_ready until rst.
